// File: rtl/writeback_queue_if.sv
// writeback_queue_if: allocation, memory-response, register-write and status signals of the writeback queue.
// Forwarding query signals exist only when WB_FORWARD_EN is defined.
interface writeback_queue_if #(parameter int DEPTH = 4, parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic                       allocValid;
  logic                       allocIsLoad;
  logic [ADDR_W-1:0]          allocRd;
  logic [DATA_W-1:0]          allocData;
  logic                       allocReady;
  logic                       memRespValid;
  logic [DATA_W-1:0]          memRespData;
  logic [ADDR_W-1:0]          writeRpoint;
  logic [DATA_W-1:0]          writeData;
  logic                       writeEnable;
  logic [31:0]                busyMask;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       errSticky;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0]          qRd;
  logic                       qHit;
  logic [DATA_W-1:0]          qData;
  modport master (output allocValid, allocIsLoad, allocRd, allocData, memRespValid, memRespData, qRd,
                  input allocReady, writeRpoint, writeData, writeEnable, busyMask, count, errSticky, qHit, qData);
  modport slave (input allocValid, allocIsLoad, allocRd, allocData, memRespValid, memRespData, qRd,
                 output allocReady, writeRpoint, writeData, writeEnable, busyMask, count, errSticky, qHit, qData);
`else
  modport master (output allocValid, allocIsLoad, allocRd, allocData, memRespValid, memRespData,
                  input allocReady, writeRpoint, writeData, writeEnable, busyMask, count, errSticky);
  modport slave (input allocValid, allocIsLoad, allocRd, allocData, memRespValid, memRespData,
                 output allocReady, writeRpoint, writeData, writeEnable, busyMask, count, errSticky);
`endif
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order register writeback queue with in-order load fill and busy scoreboard.
// Define WB_FORWARD_EN to add the combinational forwarding query (qRd/qHit/qData).
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0]  vld_q, vld_d, rdy_q, rdy_d;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [ADDR_W-1:0] rd_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     slot [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] wrp_q, wrp_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              push, pop, fill, fill_found;
  logic [31:0]       busy;
  assign bus.allocReady  = count_q < CW'(DEPTH);
  assign bus.writeRpoint = wrp_q;
  assign bus.writeData   = wd_q;
  assign bus.writeEnable = we_q;
  assign bus.count       = count_q;
  assign bus.errSticky   = err_q;
  assign bus.busyMask    = busy & ~32'd1;
  assign push = bus.allocValid && bus.allocReady;
  assign pop  = vld_q[head_q] && rdy_q[head_q];
  assign fill = bus.memRespValid && fill_found;
  // slot[i] is the i-th oldest position; the load target is the oldest valid, not-ready entry
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = head_q;
    busy       = we_q ? 32'd1 << wrp_q : 32'd0;
    for (int i = 0; i < DEPTH; i++) slot[i] = head_q + PW'(i);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fill_found = (vld_q[slot[i]] && !rdy_q[slot[i]]) ? 1'b1 : fill_found;
      fill_idx   = (vld_q[slot[i]] && !rdy_q[slot[i]]) ? slot[i] : fill_idx;
      busy       = vld_q[i] ? busy | (32'd1 << rd_q[i]) : busy;
    end
  end
  always_comb begin
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    we_d    = pop && rd_q[head_q] != '0;
    wrp_d   = we_d ? rd_q[head_q] : wrp_q;
    wd_d    = we_d ? data_q[head_q] : wd_q;
    err_d   = err_q || (bus.allocValid && !bus.allocReady) || (bus.memRespValid && !fill_found);
    if (pop) vld_d[head_q] = 1'b0;
    if (fill) begin
      rdy_d[fill_idx]  = 1'b1;
      data_d[fill_idx] = bus.memRespData;
    end
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      rdy_d[tail_q]  = !bus.allocIsLoad;
      rd_d[tail_q]   = bus.allocRd;
      data_d[tail_q] = bus.allocData;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wrp_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wrp_q   <= wrp_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end
`ifdef WB_FORWARD_EN
  logic              fwd_m, fwd_r;
  logic [DATA_W-1:0] fwd_data;
  // walk oldest to youngest so the youngest match wins; the write-port stage is older than any entry
  always_comb begin
    fwd_m    = we_q && wrp_q == bus.qRd;
    fwd_r    = fwd_m;
    fwd_data = wd_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[slot[i]] && rd_q[slot[i]] == bus.qRd) begin
        fwd_m    = 1'b1;
        fwd_r    = rdy_q[slot[i]];
        fwd_data = data_q[slot[i]];
      end
    end
  end
  assign bus.qHit  = fwd_m && fwd_r && bus.qRd != '0;
  assign bus.qData = fwd_data;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed checks of writeback_queue commit order, load fill, full/error and reset.
module tb_writeback_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  writeback_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) wb ();
  writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(wb.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input logic is_load, input logic [4:0] rd, input logic [31:0] d);
    wb.allocValid = 1'b1;
    wb.allocIsLoad = is_load;
    wb.allocRd = rd;
    wb.allocData = d;
    tick();
    wb.allocValid = 1'b0;
  endtask
  task automatic resp(input logic [31:0] d);
    wb.memRespValid = 1'b1;
    wb.memRespData = d;
    tick();
    wb.memRespValid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  task automatic check_wr(input string tag, input logic we, input logic [4:0] rp, input logic [31:0] wd);
    check({tag, "_we"}, 32'(wb.writeEnable), 32'(we));
    if (we) begin
      check({tag, "_rp"}, 32'(wb.writeRpoint), 32'(rp));
      check({tag, "_wd"}, wb.writeData, wd);
    end
  endtask
  initial begin
    wb.allocValid = 1'b0;
    wb.allocIsLoad = 1'b0;
    wb.allocRd = '0;
    wb.allocData = '0;
    wb.memRespValid = 1'b0;
    wb.memRespData = '0;
`ifdef WB_FORWARD_EN
    wb.qRd = '0;
`endif
    #12;
    check("rst_count", 32'(wb.count), 0);
    check("rst_we", 32'(wb.writeEnable), 0);
    check("rst_rp", 32'(wb.writeRpoint), 0);
    check("rst_wd", wb.writeData, 0);
    check("rst_busy", wb.busyMask, 0);
    check("rst_err", 32'(wb.errSticky), 0);
    check("rst_ready", 32'(wb.allocReady), 1);
    rst_n = 1'b1;
    // single ALU entry
    alloc(1'b0, 5'd5, 32'h1234);
    check("alu_count1", 32'(wb.count), 1);
    check("alu_busy1", wb.busyMask, 32'h20);
    check_wr("alu_e1", 1'b0, 5'd0, 32'h0);
    tick();
    check_wr("alu_e2", 1'b1, 5'd5, 32'h1234);
    check("alu_busy2", wb.busyMask, 32'h20);
    check("alu_count2", 32'(wb.count), 0);
    tick();
    check_wr("alu_e3", 1'b0, 5'd0, 32'h0);
    check("alu_busy3", wb.busyMask, 0);
    check("alu_hold", wb.writeData, 32'h1234);
    // load blocks a younger ALU entry until filled
    alloc(1'b1, 5'd3, 32'hDEAD);
    alloc(1'b0, 5'd4, 32'd7);
    check("ld_count", 32'(wb.count), 2);
    check("ld_busy", wb.busyMask, 32'h18);
    check_wr("ld_block1", 1'b0, 5'd0, 32'h0);
    tick();
    check_wr("ld_block2", 1'b0, 5'd0, 32'h0);
    resp(32'hAA);
    check_wr("ld_fill", 1'b0, 5'd0, 32'h0);
    check("ld_count2", 32'(wb.count), 2);
    tick();
    check_wr("ld_r3", 1'b1, 5'd3, 32'hAA);
    check("ld_busy2", wb.busyMask, 32'h18);
    tick();
    check_wr("ld_r4", 1'b1, 5'd4, 32'd7);
    check("ld_count3", 32'(wb.count), 0);
    tick();
    check("ld_busy3", wb.busyMask, 0);
    check("ld_err", 32'(wb.errSticky), 0);
    // fill to full with loads, overflow attempt, then drain
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(8 + i), 32'h0);
    check("full_count", 32'(wb.count), 4);
    check("full_ready", 32'(wb.allocReady), 0);
    check("full_busy", wb.busyMask, 32'h0F00);
    alloc(1'b1, 5'd12, 32'h0);
    check("ovf_err", 32'(wb.errSticky), 1);
    check("ovf_count", 32'(wb.count), 4);
    check("ovf_busy", wb.busyMask, 32'h0F00);
    resp(32'h10);
    check_wr("drain_f0", 1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 5; i++) begin
      if (i < 4) resp(32'(32'h10 + i));
      else tick();
      check_wr("drain", 1'b1, 5'(8 + i - 1), 32'(32'h10 + i - 1));
    end
    check("drain_count", 32'(wb.count), 0);
    do_reset();
    check("rst2_err", 32'(wb.errSticky), 0);
    // R0 writes retire silently
    alloc(1'b0, 5'd0, 32'hFF);
    check("r0_count", 32'(wb.count), 1);
    check("r0_busy", wb.busyMask, 0);
    tick();
    check_wr("r0_we", 1'b0, 5'd0, 32'h0);
    check("r0_count2", 32'(wb.count), 0);
    check("r0_busy2", wb.busyMask, 0);
    // stray memory response
    resp(32'h77);
    check("stray_err", 32'(wb.errSticky), 1);
    check("stray_count", 32'(wb.count), 0);
    // reset mid-drain
    alloc(1'b0, 5'd7, 32'd1);
    alloc(1'b0, 5'd8, 32'd2);
    check_wr("mid_we", 1'b1, 5'd7, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we0", 32'(wb.writeEnable), 0);
    check("mid_rp0", 32'(wb.writeRpoint), 0);
    check("mid_wd0", wb.writeData, 0);
    check("mid_count0", 32'(wb.count), 0);
    check("mid_busy0", wb.busyMask, 0);
    check("mid_err0", 32'(wb.errSticky), 0);
    rst_n = 1'b1;
    tick();
    check("mid_after", 32'(wb.count), 0);
`ifdef WB_FORWARD_EN
    wb.qRd = 5'd6;
    alloc(1'b0, 5'd6, 32'd9);
    check("fwd_alu", 32'(wb.qHit), 1);
    check("fwd_alu_d", wb.qData, 32'd9);
    alloc(1'b1, 5'd6, 32'h0);
    check("fwd_pend", 32'(wb.qHit), 0);
    resp(32'h55);
    check("fwd_hit", 32'(wb.qHit), 1);
    check("fwd_data", wb.qData, 32'h55);
    wb.qRd = 5'd0;
    #1;
    check("fwd_r0", 32'(wb.qHit), 0);
    tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
